// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian bytes into 32-bit words, writes
// them to instruction memory, then releases the CPU reset. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH       = 10,
  parameter int BASE_ADDR        = 0,
  parameter int MAX_WORDS        = 1024,
  parameter int CPU_RESET_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  // Byte port: a byte moves only on a cycle where byte_valid && byte_ready are both high.
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic [31:0]           expected_sum,
  output logic [31:0]           checksum,
`endif
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam int REL_LAST = (CPU_RESET_CYCLES > 0) ? CPU_RESET_CYCLES - 1 : 0;

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] wbuf;
  logic [15:0] rel_cnt;

  logic                  accept;
  logic                  restart;
  logic                  full;
  logic [4:0]            shamt;
  logic [31:0]           merged;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  sum_ok;

  assign dbg_state = state;
  assign accept    = (state == S_LOAD) && byte_valid && byte_ready;
  assign restart   = start && (state == S_IDLE || state == S_RUN || state == S_ERROR);
  assign full      = (word_count == (ADDR_WIDTH+1)'(MAX_WORDS));
  // Bytes land MSB-first; an early byte_last leaves the unfilled low bytes at zero.
  assign shamt     = {2'd3 - idx, 3'b000};
  assign merged    = wbuf | ({24'd0, byte_data} << shamt);
  assign next_addr = ADDR_WIDTH'(BASE_ADDR) + word_count[ADDR_WIDTH-1:0];

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_next;
  assign sum_next = checksum + merged;
  assign sum_ok   = (sum_next == expected_sum);
`else
  assign sum_ok   = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      wbuf       <= 32'd0;
      rel_cnt    <= 16'd0;
      cpu_reset  <= 1'b1;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum   <= 32'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        state      <= S_LOAD;
        idx        <= 2'd0;
        wbuf       <= 32'd0;
        cpu_reset  <= 1'b1;
        byte_ready <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum   <= 32'd0;
`endif
      end else begin
        case (state)
          S_LOAD: begin
            if (accept) begin
              if (full) begin
                state      <= S_ERROR;
                error      <= 1'b1;
                busy       <= 1'b0;
                byte_ready <= 1'b0;
              end else if (idx == 2'd3 || byte_last) begin
                mem_we     <= 1'b1;
                mem_addr   <= next_addr;
                mem_wdata  <= merged;
                word_count <= word_count + 1'b1;
                idx        <= 2'd0;
                wbuf       <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                checksum   <= sum_next;
`endif
                if (byte_last) begin
                  byte_ready <= 1'b0;
                  rel_cnt    <= 16'd0;
                  if (sum_ok) begin
                    state <= S_RELEASE;
                  end else begin
                    state <= S_ERROR;
                    error <= 1'b1;
                    busy  <= 1'b0;
                  end
                end
              end else begin
                wbuf <= merged;
                idx  <= idx + 2'd1;
              end
            end
          end
          S_RELEASE: begin
            // Counts cycles after the final write strobe before letting the CPU run.
            if (rel_cnt == 16'(REL_LAST)) begin
              state     <= S_RUN;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              rel_cnt <= rel_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboarded memory writes, release timing,
// overflow, mid-session reset and (when IMEM_LOADER_CHECKSUM_EN is defined) checksum.
module tb_imem_loader;
  localparam int AW = 10;
  localparam int MAXW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [7:0]    byte_data = 8'd0;
  logic          byte_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset, busy, done, error;
  logic [AW:0]   word_count;
  logic [2:0]    dbg_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   expected_sum = 32'd0;
  logic [31:0]   checksum;
`endif

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .MAX_WORDS(MAXW), .CPU_RESET_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .expected_sum(expected_sum), .checksum(checksum),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int we_pulses = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] got_q[$];
  logic [7:0]     stim_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: records every strobe seen on the memory port.
  always @(negedge clk) begin
    if (mem_we) begin
      got_q.push_back({mem_addr, mem_wdata});
      we_pulses = we_pulses + 1;
      last_we_cyc = cyc;
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Pushes the expected words for stim_q, then drives it; returns whether byte_ready dropped in LOAD.
  task automatic send_stream(input bit toggle, input bit use_last, input int exp_words,
                             output bit ready_dropped);
    int n = stim_q.size();
    int i = 0;
    int budget = 0;
    bit phase = 1'b0;
    ready_dropped = 1'b0;
    for (int w = 0; w < exp_words; w++) begin
      logic [31:0] word = 32'd0;
      for (int j = 0; j < 4; j++) begin
        int k = 4 * w + j;
        word = {word[23:0], (k < n) ? stim_q[k] : 8'h00};
      end
      exp_q.push_back({AW'(w), word});
    end
    while (i < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (dbg_state == 3'd1 && !byte_ready) ready_dropped = 1'b1;
      if (toggle && phase) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = stim_q[i];
        byte_last  = use_last && (i == n - 1);
      end
      if (toggle) phase = ~phase;
      if (byte_valid && byte_ready) i++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (i < n) begin
      errors++;
      $display("FAIL stream_timeout: sent %0d of %0d bytes", i, n);
    end
  endtask

  task automatic wait_release(input int exp_wc);
    int budget = 0;
    while (cpu_reset && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (cpu_reset !== 1'b0 || (cyc - last_we_cyc) !== 4) begin
      errors++;
      $display("FAIL release_delay: got %0d cycles (cpu_reset=%b), expected 4", cyc - last_we_cyc, cpu_reset);
    end
    checks++;
    if ({done, busy, byte_ready, word_count} !== {1'b1, 1'b0, 1'b0, (AW+1)'(exp_wc)}) begin
      errors++;
      $display("FAIL run_state: done=%b busy=%b ready=%b wc=%0d, expected 1 0 0 %0d", done, busy, byte_ready, word_count, exp_wc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_reset, byte_ready, mem_we, busy, done, error} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100000", {cpu_reset, byte_ready, mem_we, busy, done, error});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== 32'd0 || word_count !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%0h wdata=%08h wc=%0d expected zeros", mem_addr, mem_wdata, word_count);
    end
    reset = 1'b0;
    // byte_valid without start must be ignored in IDLE.
    @(negedge clk); byte_valid = 1'b1; byte_data = 8'h55;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (we_pulses !== 0 || byte_ready !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL idle_ignore: pulses=%0d ready=%b state=%0d expected 0 0 0", we_pulses, byte_ready, dbg_state);
    end
  endtask

  task automatic test_basic();
    bit dropped;
    do_start();
    checks++;
    if ({byte_ready, busy, cpu_reset, done} !== 4'b1110) begin
      errors++;
      $display("FAIL start_flags: got %b expected 1110", {byte_ready, busy, cpu_reset, done});
    end
    stim_q = '{8'h20, 8'h09, 8'h00, 8'h03, 8'h20, 8'h0A, 8'h00, 8'h0A};
    send_stream(1'b0, 1'b1, 2, dropped);
    wait_release(2);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d writes expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [AW+31:0] g = got_q.pop_front();
      logic [AW+31:0] e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL basic_write: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_partial();
    bit dropped;
    int base = we_pulses;
    do_start();
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rerun_flags: cpu_reset=%b done=%b expected 1 0", cpu_reset, done);
    end
    stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_stream(1'b0, 1'b1, 2, dropped);
    wait_release(2);
    checks++;
    if (we_pulses - base !== 2) begin
      errors++;
      $display("FAIL partial_pulses: got %0d expected 2", we_pulses - base);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [AW+31:0] g = got_q.pop_front();
      logic [AW+31:0] e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL partial_write: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back_toggle();
    bit dropped;
    int base = we_pulses;
    do_start();
    stim_q = '{8'h20, 8'h09, 8'h00, 8'h03, 8'h20, 8'h0A, 8'h00, 8'h0A};
    send_stream(1'b1, 1'b1, 2, dropped);
    wait_release(2);
    checks++;
    if (dropped !== 1'b0 || we_pulses - base !== 2) begin
      errors++;
      $display("FAIL toggle_flow: ready_dropped=%b pulses=%0d expected 0 2", dropped, we_pulses - base);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [AW+31:0] g = got_q.pop_front();
      logic [AW+31:0] e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL toggle_write: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    bit dropped;
    int base = we_pulses;
    do_start();
    stim_q.delete();
    for (int i = 0; i < 9; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    send_stream(1'b0, 1'b0, 2, dropped);
    repeat (3) @(negedge clk);
    checks++;
    if ({error, cpu_reset, byte_ready, busy, dbg_state} !== {4'b1100, 3'd4}) begin
      errors++;
      $display("FAIL overflow_flags: err=%b cpu_rst=%b ready=%b busy=%b st=%0d expected 1 1 0 0 4", error, cpu_reset, byte_ready, busy, dbg_state);
    end
    checks++;
    if (we_pulses - base !== 2) begin
      errors++;
      $display("FAIL overflow_pulses: got %0d expected 2", we_pulses - base);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [AW+31:0] g = got_q.pop_front();
      logic [AW+31:0] e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL overflow_write: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    do_start();
    checks++;
    if (error !== 1'b0 || dbg_state !== 3'd1) begin
      errors++;
      $display("FAIL overflow_restart: err=%b st=%0d expected 0 1", error, dbg_state);
    end
    stim_q = '{8'hDE, 8'hAD, 8'hBE};
    send_stream(1'b0, 1'b1, 1, dropped);
    wait_release(1);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [AW+31:0] g = got_q.pop_front();
      logic [AW+31:0] e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL restart_write: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit dropped;
    do_start();
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_stream(1'b0, 1'b0, 1, dropped);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cpu_reset, byte_ready, mem_we, busy, done, error} !== 6'b100000 || word_count !== '0 ||
        mem_addr !== '0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b wc=%0d addr=%0h wdata=%08h expected 100000 0 0 0",
               {cpu_reset, byte_ready, mem_we, busy, done, error}, word_count, mem_addr, mem_wdata);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [AW+31:0] g = got_q.pop_front();
      logic [AW+31:0] e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL midreset_write: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    @(negedge clk); reset = 1'b0;
    do_start();
    stim_q = '{8'hC0, 8'hFF, 8'hEE, 8'h11};
    send_stream(1'b0, 1'b1, 1, dropped);
    wait_release(1);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [AW+31:0] g = got_q.pop_front();
      logic [AW+31:0] e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL postreset_write: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit dropped;
    expected_sum = 32'h4013000D;
    do_start();
    stim_q = '{8'h20, 8'h09, 8'h00, 8'h03, 8'h20, 8'h0A, 8'h00, 8'h0A};
    send_stream(1'b0, 1'b1, 2, dropped);
    wait_release(2);
    checks++;
    if (checksum !== 32'h4013000D) begin
      errors++;
      $display("FAIL checksum_value: got %08h expected 4013000d", checksum);
    end
    got_q.delete(); exp_q.delete();
    expected_sum = 32'd0;
    do_start();
    send_stream(1'b0, 1'b1, 2, dropped);
    repeat (8) @(negedge clk);
    checks++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || dbg_state !== 3'd4) begin
      errors++;
      $display("FAIL checksum_mismatch: err=%b cpu_rst=%b done=%b st=%0d expected 1 1 0 4", error, cpu_reset, done, dbg_state);
    end
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back_toggle();
    test_overflow();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader; writes a CPU image into the pipelined CPU's instruction/data memory and then releases the CPU from reset.
- It is the write side of the memory-image path: it fills memory before execution, and result checkers read the register file after execution.
- Sits between a host byte source (UART/JTAG shim or bench) and the memory write port; owns the CPU reset line.

Parameters:
- ADDR_WIDTH, 10, word-address width of mem_addr
- BASE_ADDR, 0, first word address written
- MAX_WORDS, 1024, maximum words per image
- CPU_RESET_CYCLES, 4, cycles cpu_reset stays high after the final write

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a load session
- byte_valid  in  1  byte_data valid
- byte_ready  out  1  loader accepts a byte this cycle
- byte_data  in  8  image byte, big-endian order (first byte is MSB of word)
- byte_last  in  1  qualifies the final byte of the image
- mem_we  out  1  one-cycle memory write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  word to write
- cpu_reset  out  1  CPU reset, active-high
- busy  out  1  high in LOAD/RELEASE
- done  out  1  image loaded, CPU running
- error  out  1  overflow (or checksum mismatch)
- word_count  out  ADDR_WIDTH+1  words written this session

Behaviour:
- Async reset: state=IDLE, cpu_reset=1, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, word_count=0, byte index=0. All outputs are registered.
- States: IDLE, LOAD, RELEASE, RUN, ERROR.
- IDLE: cpu_reset=1. byte_valid is ignored. start -> LOAD; clears word_count, byte index and error; byte_ready=1 from the next cycle.
- LOAD: a byte is accepted when byte_valid && byte_ready. Accepted bytes shift in MSB-first; the byte index counts 0..3.
  - Accepting byte index 3: on the next cycle mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+word_count, mem_wdata=assembled word. word_count increments in the same cycle.
  - byte_ready stays high, so back-to-back bytes run at 1 byte/cycle with no bubbles.
  - byte_last on index k<3: the word is zero-padded in the low bytes and written the same way.
  - byte_last: -> RELEASE once the final write issues; byte_ready=0.
  - A byte accepted while word_count==MAX_WORDS -> ERROR; no write occurs and the byte is dropped.
  - start is ignored in LOAD.
- RELEASE: a counter holds cpu_reset=1 for CPU_RESET_CYCLES cycles after the final mem_we cycle, then -> RUN.
- RUN: cpu_reset=0, done=1, busy=0, byte_ready=0. start -> LOAD; on the next cycle cpu_reset=1 and done=0.
- ERROR: error=1, cpu_reset=1, byte_ready=0, busy=0. Only start (-> LOAD, error cleared) or reset exits.
- Reset mid-operation: any partial word is discarded. Words already written stay in memory; there is no clearing. The next session restarts at BASE_ADDR.
- Address arithmetic: mem_addr is the low ADDR_WIDTH bits of BASE_ADDR+word_count and never wraps within a session, because MAX_WORDS enforces the limit.
- byte_last on an empty image (first byte) writes one padded word; a zero-byte image is not possible.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - adds input expected_sum[31:0] and output checksum[31:0];
  - checksum = 32-bit wrapping sum of every written word, padding included; it is cleared on start and on reset;
  - after the final write, a mismatch with expected_sum -> ERROR instead of RELEASE.
- Undefined: neither port exists; the final write always proceeds to RELEASE.

Test Plan:
- Stream 20 09 00 03 20 0A 00 0A, byte_last on the 8th byte -> mem[0]=0x20090003, mem[1]=0x200A000A, word_count=2, cpu_reset falls exactly 4 cycles after the last mem_we, done=1.
- Stream AA BB CC DD 11 22, byte_last on 0x22 -> mem[1]=0x11220000, exactly 2 mem_we pulses.
- Same 8 bytes with byte_valid toggled 1/0 every cycle -> identical memory contents, no spurious mem_we, byte_ready never drops in LOAD.
- MAX_WORDS=2, stream 9 bytes -> 9th byte: error=1, no 3rd write, cpu_reset=1; then start -> error=0, LOAD, writes restart at address 0.
- Assert reset after 5 bytes -> all outputs at reset values immediately; a new session writes its first word to address 0.
- With IMEM_LOADER_CHECKSUM_EN, first stream:
  - expected_sum=0x4013000D -> RUN, checksum=0x4013000D;
  - expected_sum=0 -> ERROR, cpu_reset stays 1.
